first_phase_pipe: RTL and testbench
===================================

FIRST_PHASE_PIPE -- requirements
Module: first_phase_pipe

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand width: 32 for single or 64 for double IEEE-754.
REQ-002 SHALL have localparam EW, derived as 8 when W=32 and 11 when W=64, meaning exponent width.
REQ-003 SHALL have localparam MW, derived as W-1-EW, meaning mantissa width.
REQ-004 SHALL provide these ports:
- clk  in  1  system clock; the single clock of the block
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operand pair
- add_subt  in  1  0=add, 1=subtract (X-Y)
- Data_X  in  W  operand X, IEEE-754
- Data_Y  in  W  operand Y, IEEE-754
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- DMP  out  W  larger-magnitude operand, sign corrected
- DmP  out  W  smaller-magnitude operand, sign corrected
- exp_diff  out  EW  exponent of DMP minus exponent of DmP
- eff_sub  out  1  effective operation is subtraction
- swap  out  1  DMP was taken from Y
- spec_flags  out  3  {nan, inf, zero} special-case flags

Function
REQ-005 SHALL transfer input when in_valid&in_ready, and transfer output when out_valid&out_ready.
REQ-006 Stage 1 SHALL register X, Y', and a valid bit on input transfer.
- Y' is Data_Y with its sign bit inverted when add_subt=1.
REQ-007 Stage 2 SHALL compare X[W-2:0] against Y'[W-2:0] as unsigned values, with gt = X>Y'.
REQ-008 Stage 2 SHALL register, on advance:
- DMP = gt ? X : Y'
- DmP = gt ? Y' : X
- swap = ~gt
- eff_sub = DMP[W-1]^DmP[W-1]
- exp_diff = DMP[W-2:MW] - DmP[W-2:MW], unsigned and never negative
REQ-009 Equal magnitudes SHALL give gt=0, so DMP=Y', swap=1, exp_diff=0.
REQ-010 Stage 2 SHALL advance when !out_valid | out_ready; stage 1 SHALL advance when !s1_valid | stage-2 advance.
REQ-011 in_ready SHALL be !s1_valid | stage-2 advance, and SHALL be combinational with no path from in_valid.
REQ-012 Latency SHALL be 2 cycles from input transfer to out_valid; throughput SHALL be 1 per cycle while out_ready=1.
REQ-013 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; once both stages are full, in_ready SHALL be 0.
REQ-014 Order SHALL be preserved; no transfer SHALL be lost or duplicated under any stall pattern.
REQ-015 Simultaneous output transfer and input transfer with a full pipeline SHALL shift both stages in the same cycle.

Reset
REQ-016 rst=0 SHALL asynchronously clear all stage valid bits and all data registers to 0.
- Outputs go to out_valid=0, DMP=DmP=0, exp_diff=0, eff_sub=0, swap=0, spec_flags=0.
REQ-017 During reset, in_ready SHALL be 1.
REQ-018 Reset asserted mid-operation SHALL discard in-flight data; the first post-reset transfer SHALL behave as from idle.

Configuration
REQ-019 With macro FIRST_PHASE_SPECIAL_CASE_EN defined, stage 2 SHALL register spec_flags in step with DMP:
- nan = either operand NaN, or both infinite with eff_sub=1
- inf = either operand infinite and nan=0
- zero = both operands zero (exponent and mantissa 0)
REQ-020 Without FIRST_PHASE_SPECIAL_CASE_EN, spec_flags SHALL be tied to 3'b000 and no detection logic SHALL be synthesised.

Verification
REQ-021 W=32, X=0x40400000, Y=0x3F800000, add_subt=0 -> 2 cycles later DMP=0x40400000, DmP=0x3F800000, exp_diff=1, eff_sub=0, swap=0.
REQ-022 W=32, X=0x3F800000, Y=0x40400000, add_subt=1 -> DMP=0xC0400000, DmP=0x3F800000, exp_diff=1, eff_sub=1, swap=1.
REQ-023 X=Y=0x3F800000, add_subt=1 -> DMP=0xBF800000, DmP=0x3F800000, exp_diff=0, eff_sub=1, swap=1.
REQ-024 Back-to-back stream of 4 ops with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted, outputs held; on release all 4 emerge in order, one per cycle.
REQ-025 rst driven 0 between clock edges while out_valid=1 -> out_valid=0 and in_ready=1 immediately; first later op has 2-cycle latency.
REQ-026 With FIRST_PHASE_SPECIAL_CASE_EN, X=Y=0x7F800000, add_subt=1 -> spec_flags=3'b100; without the macro -> spec_flags=3'b000.

Source files
------------

// File: rtl/first_phase_pipe.sv
// First phase of an IEEE-754 add/sub: operand swap, effective-op and exponent-difference pipeline.
// Optional special-case detection is enabled by defining FIRST_PHASE_SPECIAL_CASE_EN.
module first_phase_pipe #(
    parameter  int W  = 32,
    localparam int EW = (W == 64) ? 11 : 8,
    localparam int MW = W - 1 - EW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          add_subt,
    input  logic [W-1:0]  Data_X,
    input  logic [W-1:0]  Data_Y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  DMP,
    output logic [W-1:0]  DmP,
    output logic [EW-1:0] exp_diff,
    output logic          eff_sub,
    output logic          swap,
    output logic [2:0]    spec_flags
);

    logic          vld_p1;
    logic          vld_p2;
    logic [W-1:0]  x_p1;
    logic [W-1:0]  y_p1;
    logic [W-1:0]  dmp_p2;
    logic [W-1:0]  dmin_p2;
    logic [EW-1:0] ediff_p2;
    logic          eff_p2;
    logic          swap_p2;

    logic          adv_p2;
    logic          adv_p1;
    logic [W-1:0]  y_in;
    logic          gt_p1;
    logic [W-1:0]  dmp_nxt;
    logic [W-1:0]  dmin_nxt;
    logic [EW-1:0] ediff_nxt;

    // Handshake: stage 2 frees when its result leaves; in_ready never looks at in_valid.
    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    assign y_in = {Data_Y[W-1] ^ add_subt, Data_Y[W-2:0]};

    // ---- stage 1: capture X and sign-adjusted Y ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                x_p1 <= Data_X;
                y_p1 <= y_in;
            end
        end
    end

    // Equal magnitudes resolve to Y' as the larger operand.
    assign gt_p1     = x_p1[W-2:0] > y_p1[W-2:0];
    assign dmp_nxt   = gt_p1 ? x_p1 : y_p1;
    assign dmin_nxt  = gt_p1 ? y_p1 : x_p1;
    assign ediff_nxt = dmp_nxt[W-2:MW] - dmin_nxt[W-2:MW];

    // ---- stage 2: ordered operands and derived fields ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2   <= 1'b0;
            dmp_p2   <= '0;
            dmin_p2  <= '0;
            ediff_p2 <= '0;
            eff_p2   <= 1'b0;
            swap_p2  <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                dmp_p2   <= dmp_nxt;
                dmin_p2  <= dmin_nxt;
                ediff_p2 <= ediff_nxt;
                eff_p2   <= x_p1[W-1] ^ y_p1[W-1];
                swap_p2  <= !gt_p1;
            end
        end
    end

`ifdef FIRST_PHASE_SPECIAL_CASE_EN
    function automatic logic is_nan(input logic [W-1:0] v);
        return (v[W-2:MW] == {EW{1'b1}}) && (v[MW-1:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [W-1:0] v);
        return (v[W-2:MW] == {EW{1'b1}}) && (v[MW-1:0] == '0);
    endfunction

    function automatic logic is_zero(input logic [W-1:0] v);
        return v[W-2:0] == '0;
    endfunction

    logic       nan_p1;
    logic       inf_p1;
    logic       zero_p1;
    logic [2:0] flags_p2;

    // Inf minus inf of like magnitude is the invalid case folded into nan.
    assign nan_p1  = is_nan(x_p1) || is_nan(y_p1) ||
                     (is_inf(x_p1) && is_inf(y_p1) && (x_p1[W-1] ^ y_p1[W-1]));
    assign inf_p1  = !nan_p1 && (is_inf(x_p1) || is_inf(y_p1));
    assign zero_p1 = is_zero(x_p1) && is_zero(y_p1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_p2 <= 3'b000;
        end else if (adv_p2 && vld_p1) begin
            flags_p2 <= {nan_p1, inf_p1, zero_p1};
        end
    end

    assign spec_flags = flags_p2;
`else
    assign spec_flags = 3'b000;
`endif

    assign out_valid = vld_p2;
    assign DMP       = dmp_p2;
    assign DmP       = dmin_p2;
    assign exp_diff  = ediff_p2;
    assign eff_sub   = eff_p2;
    assign swap      = swap_p2;

endmodule

// File: tb/tb_first_phase_pipe.sv
// Self-checking bench for first_phase_pipe (W=32): queue-based reference model plus directed literal cases.
module tb_first_phase_pipe;

    localparam int W  = 32;
    localparam int EW = 8;
    localparam int MW = 23;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          add_subt;
    logic [W-1:0]  Data_X;
    logic [W-1:0]  Data_Y;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  DMP;
    logic [W-1:0]  DmP;
    logic [EW-1:0] exp_diff;
    logic          eff_sub;
    logic          swap;
    logic [2:0]    spec_flags;

    first_phase_pipe #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .add_subt(add_subt), .Data_X(Data_X), .Data_Y(Data_Y),
        .out_valid(out_valid), .out_ready(out_ready), .DMP(DMP), .DmP(DmP),
        .exp_diff(exp_diff), .eff_sub(eff_sub), .swap(swap), .spec_flags(spec_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  dmp;
        logic [W-1:0]  dmn;
        logic [EW-1:0] ed;
        logic          eff;
        logic          sw;
        logic [2:0]    fl;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic f_nan(input logic [W-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'h0);
    endfunction
    function automatic logic f_inf(input logic [W-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'h0);
    endfunction

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic sub, input int acc);
        exp_t e;
        logic [W-1:0] yp;
        longint unsigned mx, my;
        int ebig, esmall;
        logic nan, inf, zero;
        yp = y;
        if (sub) yp[W-1] = ~yp[W-1];
        mx = longint'(x & 32'h7FFF_FFFF);
        my = longint'(yp & 32'h7FFF_FFFF);
        if (mx > my) begin
            e.dmp = x;  e.dmn = yp; e.sw = 1'b0;
        end else begin
            e.dmp = yp; e.dmn = x;  e.sw = 1'b1;
        end
        ebig   = int'(e.dmp[30:23]);
        esmall = int'(e.dmn[30:23]);
        e.ed   = EW'(ebig - esmall);
        e.eff  = x[W-1] ^ yp[W-1];
        nan  = f_nan(x) || f_nan(yp) || (f_inf(x) && f_inf(yp) && e.eff);
        inf  = !nan && (f_inf(x) || f_inf(yp));
        zero = (mx == 0) && (my == 0);
`ifdef FIRST_PHASE_SPECIAL_CASE_EN
        e.fl = {nan, inf, zero};
`else
        e.fl = 3'b000;
        if (nan || inf || zero) e.fl = 3'b000;
`endif
        e.acc = acc;
        return e;
    endfunction

    // Reference scoreboard: checked at every falling edge, transfers applied at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
        end else begin
            logic exp_ov;
            exp_ov = (q.size() > 0) && (q[0].acc + 1 <= edge_cnt);
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
            if (out_valid && exp_ov) begin
                chk("DMP", 64'(DMP), 64'(q[0].dmp));
                chk("DmP", 64'(DmP), 64'(q[0].dmn));
                chk("exp_diff", 64'(exp_diff), 64'(q[0].ed));
                chk("eff_sub", 64'(eff_sub), 64'(q[0].eff));
                chk("swap", 64'(swap), 64'(q[0].sw));
                chk("spec_flags", 64'(spec_flags), 64'(q[0].fl));
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(Data_X, Data_Y, add_subt, edge_cnt + 1));
        end
    end

    // Present one operand pair and hold it until accepted; starts and ends just after a rising edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        logic acc;
        bit   done;
        in_valid = 1'b1; Data_X = x; Data_Y = y; add_subt = sub;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) done = 1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // Idle pipeline, out_ready=1: one op, checked against literal results two cycles later.
    task automatic direct(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub, input logic [W-1:0] e_dmp, input logic [W-1:0] e_dmn,
                          input logic [EW-1:0] e_ed, input logic e_eff, input logic e_sw,
                          input logic [2:0] e_fl);
        in_valid = 1'b1; Data_X = x; Data_Y = y; add_subt = sub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_lat1_ov"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({nm, "_lat2_ov"}, 64'(out_valid), 64'd1);
        chk({nm, "_DMP"}, 64'(DMP), 64'(e_dmp));
        chk({nm, "_DmP"}, 64'(DmP), 64'(e_dmn));
        chk({nm, "_exp_diff"}, 64'(exp_diff), 64'(e_ed));
        chk({nm, "_eff_sub"}, 64'(eff_sub), 64'(e_eff));
        chk({nm, "_swap"}, 64'(swap), 64'(e_sw));
        chk({nm, "_flags"}, 64'(spec_flags), 64'(e_fl));
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] rnd_op(input logic [W-1:0] other);
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0: return {s, 31'h0};
            1: return {s, 8'hFF, 23'h0};
            2: return {s, 8'hFF, 23'($urandom) | 23'h1};
            3: return other;
            4: return {s, other[30:23], 23'($urandom)};
            5: return {s, 8'(other[30:23] + 8'($urandom_range(0, 3))), 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    logic [2:0] inf_fl;

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; add_subt = 1'b0;
        Data_X = '0; Data_Y = '0;
`ifdef FIRST_PHASE_SPECIAL_CASE_EN
        inf_fl = 3'b100;
`else
        inf_fl = 3'b000;
`endif
        #12;
        chk("reset_DMP", 64'(DMP), 64'd0);
        chk("reset_DmP", 64'(DmP), 64'd0);
        chk("reset_exp_diff", 64'(exp_diff), 64'd0);
        chk("reset_eff_swap", 64'({eff_sub, swap}), 64'd0);
        chk("reset_flags", 64'(spec_flags), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        direct("add_3_1", 32'h40400000, 32'h3F800000, 1'b0, 32'h40400000, 32'h3F800000, 8'd1, 1'b0, 1'b0, 3'b000);
        direct("sub_1_3", 32'h3F800000, 32'h40400000, 1'b1, 32'hC0400000, 32'h3F800000, 8'd1, 1'b1, 1'b1, 3'b000);
        direct("sub_eq", 32'h3F800000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h3F800000, 8'd0, 1'b1, 1'b1, 3'b000);
        direct("inf_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'hFF800000, 32'h7F800000, 8'd0, 1'b1, 1'b1, inf_fl);

        // Four back-to-back ops against a 5-cycle output stall.
        out_ready = 1'b0;
        fork
            begin
                send(32'h40400000, 32'h3F800000, 1'b0);
                send(32'h41200000, 32'h40000000, 1'b1);
                send(32'hC2C80000, 32'h3E800000, 1'b0);
                send(32'h3F000000, 32'h3F000000, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_head_DMP", 64'(DMP), 64'h40400000);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1 chk("stall_drained", 64'(q.size()), 64'd0);

        // Reset asserted between edges while a result is waiting.
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_DMP", 64'(DMP), 64'd0);
        chk("async_rst_fields", 64'({exp_diff, eff_sub, swap, spec_flags}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; out_ready = 1'b1;
        direct("post_rst", 32'h40400000, 32'h3F800000, 1'b0, 32'h40400000, 32'h3F800000, 8'd1, 1'b0, 1'b0, 3'b000);

        // Random traffic with random back-pressure and one mid-stream reset.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            Data_X    = rnd_op(Data_X);
            Data_Y    = rnd_op(Data_X);
            add_subt  = 1'($urandom_range(0, 1));
            if (c == 1500) rst = 1'b0;
            if (c == 1502) rst = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("final_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
